// File: rtl/ext_unit_pipe_if.sv
// Valid/ready bus between the beat source, the extension unit and the register-file write path.
interface ext_unit_pipe_if #(
  parameter int DATA_W = 32,
  parameter int AOFF_W = $clog2(DATA_W / 8)
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_mode;
  logic [DATA_W-1:0] in_data;
  logic [AOFF_W-1:0] in_aoff;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;

  modport master (
    output in_valid, in_mode, in_data, in_aoff, out_ready,
    input  in_ready, out_valid, out_data, out_misalign
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_aoff, out_ready,
    output in_ready, out_valid, out_data, out_misalign
  );
endinterface

// File: rtl/ext_unit_pipe.sv
// Immediate / load-data extender behind a registered valid/ready stage with a one-entry skid buffer.
module ext_unit_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int AOFF_W = $clog2(DATA_W / 8)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  ext_unit_pipe_if.slave bus
);

  if ((DATA_W % 16) != 0 || DATA_W < 32) begin : g_bad_data_w
    $error("ext_unit_pipe: DATA_W must be a multiple of 16 and at least 32");
  end
  if (IMM_W > 16 || IMM_W >= DATA_W) begin : g_bad_imm_w
    $error("ext_unit_pipe: IMM_W must be at most 16 and below DATA_W");
  end

  typedef enum logic [2:0] {
    M_ZIMM = 3'd0,
    M_SIMM = 3'd1,
    M_LUI  = 3'd2,
    M_LB   = 3'd3,
    M_LBU  = 3'd4,
    M_LH   = 3'd5,
    M_LHU  = 3'd6,
    M_PASS = 3'd7
  } mode_e;

  mode_e             mode;
  logic [IMM_W-1:0]  imm;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] res_data;
  logic              res_mis;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_mis, skid_mis;
  logic              accept, drain;

  assign mode   = mode_e'(bus.in_mode);
  assign imm    = bus.in_data[IMM_W-1:0];
  assign lane_b = bus.in_data[{bus.in_aoff, 3'b000} +: 8];
  // Halfword lane ignores aoff[0]; an odd offset is reported instead of realigned.
  assign lane_h = bus.in_data[{bus.in_aoff[AOFF_W-1:1], 4'b0000} +: 16];

  always_comb begin
    res_data = '0;
    res_mis  = 1'b0;
    case (mode)
      M_ZIMM: res_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      M_SIMM: res_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      M_LUI:  res_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      M_LB:   res_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
      M_LBU:  res_data = {{(DATA_W-8){1'b0}}, lane_b};
      M_LH, M_LHU: begin
        if (bus.in_aoff[0]) begin
          res_mis = 1'b1;
        end else if (mode == M_LH) begin
          res_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
        end else begin
          res_data = {{(DATA_W-16){1'b0}}, lane_h};
        end
      end
      M_PASS: res_data = bus.in_data;
      default: res_data = '0;
    endcase
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_mis   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_mis   <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_mis   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_mis   <= 1'b0;
    end else if (skid_valid) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (drain) begin
        main_data  <= skid_data;
        main_mis   <= skid_mis;
        skid_valid <= 1'b0;
      end
    end else if (!main_valid || drain) begin
      main_valid <= accept;
      if (accept) begin
        main_data <= res_data;
        main_mis  <= res_mis;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= res_data;
      skid_mis   <= res_mis;
    end
  end

  assign bus.in_ready     = ~skid_valid;
  assign bus.out_valid    = main_valid;
  assign bus.out_data     = main_data;
  assign bus.out_misalign = main_mis;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Directed bench for ext_unit_pipe: extension vector table plus backpressure, flush and reset sequences.
module tb_ext_unit_pipe;

  typedef enum logic [2:0] {
    ZIMM = 3'd0, SIMM = 3'd1, LUI = 3'd2, LB = 3'd3,
    LBU  = 3'd4, LH   = 3'd5, LHU = 3'd6, PASS = 3'd7
  } mode_e;

  typedef struct {
    logic        w64;
    mode_e       mode;
    logic [63:0] data;
    logic [2:0]  aoff;
    logic [63:0] exp_data;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 20;

  logic clk;
  logic reset_n;
  logic flush;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  ext_unit_pipe_if #(.DATA_W(32), .AOFF_W(2)) b32 ();
  ext_unit_pipe_if #(.DATA_W(64), .AOFF_W(3)) b64 ();

  ext_unit_pipe #(.DATA_W(32), .IMM_W(16), .AOFF_W(2)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b32)
  );
  ext_unit_pipe #(.DATA_W(64), .IMM_W(16), .AOFF_W(3)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(b64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive32(input logic v, input mode_e m, input logic [31:0] d, input logic [1:0] a);
    b32.in_valid = v;
    b32.in_mode  = m;
    b32.in_data  = d;
    b32.in_aoff  = a;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    flush   = 1'b0;
    drive32(1'b0, ZIMM, 32'h0, 2'd0);
    b32.out_ready = 1'b1;
    b64.in_valid  = 1'b0;
    b64.in_mode   = ZIMM;
    b64.in_data   = '0;
    b64.in_aoff   = '0;
    b64.out_ready = 1'b1;

    vecs[0]  = '{1'b0, ZIMM, 64'h8001,     3'd0, 64'h00008001, 1'b0};
    vecs[1]  = '{1'b0, SIMM, 64'h8001,     3'd0, 64'hFFFF8001, 1'b0};
    vecs[2]  = '{1'b0, LUI,  64'h8001,     3'd0, 64'h80010000, 1'b0};
    vecs[3]  = '{1'b0, ZIMM, 64'hDEAD8001, 3'd3, 64'h00008001, 1'b0};
    vecs[4]  = '{1'b0, SIMM, 64'h12347FFF, 3'd0, 64'h00007FFF, 1'b0};
    vecs[5]  = '{1'b0, LUI,  64'h12345678, 3'd1, 64'h56780000, 1'b0};
    vecs[6]  = '{1'b0, LB,   64'h80FF7F01, 3'd2, 64'hFFFFFFFF, 1'b0};
    vecs[7]  = '{1'b0, LBU,  64'h80FF7F01, 3'd3, 64'h00000080, 1'b0};
    vecs[8]  = '{1'b0, LB,   64'h80FF7F01, 3'd0, 64'h00000001, 1'b0};
    vecs[9]  = '{1'b0, LB,   64'h80FF7F01, 3'd1, 64'h0000007F, 1'b0};
    vecs[10] = '{1'b0, LH,   64'h80FF7F01, 3'd2, 64'hFFFF80FF, 1'b0};
    vecs[11] = '{1'b0, LHU,  64'h80FF7F01, 3'd0, 64'h00007F01, 1'b0};
    vecs[12] = '{1'b0, LH,   64'h80FF7F01, 3'd1, 64'h00000000, 1'b1};
    vecs[13] = '{1'b0, LHU,  64'h80FF7F01, 3'd3, 64'h00000000, 1'b1};
    vecs[14] = '{1'b0, PASS, 64'h80FF7F01, 3'd1, 64'h80FF7F01, 1'b0};
    vecs[15] = '{1'b1, LB,   64'h8000_0000_0000_0000, 3'd7, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[16] = '{1'b1, LHU,  64'h8000_0000_0000_0000, 3'd6, 64'h0000_0000_0000_8000, 1'b0};
    vecs[17] = '{1'b1, PASS, 64'h8000_0000_0000_0000, 3'd0, 64'h8000_0000_0000_0000, 1'b0};
    vecs[18] = '{1'b1, SIMM, 64'h0000_0000_0000_8001, 3'd0, 64'hFFFF_FFFF_FFFF_8001, 1'b0};
    vecs[19] = '{1'b1, LUI,  64'h0000_0000_0000_8001, 3'd0, 64'h8001_0000_0000_0000, 1'b0};

    // Reset state
    #1;
    chk("rst32_out_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("rst32_out_data", {32'd0, b32.out_data}, 64'd0);
    chk("rst32_out_misalign", {63'd0, b32.out_misalign}, 64'd0);
    chk("rst32_in_ready", {63'd0, b32.in_ready}, 64'd1);
    chk("rst64_out_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("rst64_in_ready", {63'd0, b64.in_ready}, 64'd1);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Vector table, back-to-back with out_ready high: result one cycle after acceptance
    for (int i = 0; i < NVEC; i++) begin
      if (!vecs[i].w64) begin
        drive32(1'b1, vecs[i].mode, vecs[i].data[31:0], vecs[i].aoff[1:0]);
        b64.in_valid = 1'b0;
        chk($sformatf("vec%0d_in_ready", i), {63'd0, b32.in_ready}, 64'd1);
        step();
        chk($sformatf("vec%0d_out_valid", i), {63'd0, b32.out_valid}, 64'd1);
        chk($sformatf("vec%0d_out_data", i), {32'd0, b32.out_data}, vecs[i].exp_data);
        chk($sformatf("vec%0d_out_misalign", i), {63'd0, b32.out_misalign}, {63'd0, vecs[i].exp_mis});
      end else begin
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b1;
        b64.in_mode  = vecs[i].mode;
        b64.in_data  = vecs[i].data;
        b64.in_aoff  = vecs[i].aoff;
        chk($sformatf("vec%0d_in_ready", i), {63'd0, b64.in_ready}, 64'd1);
        step();
        chk($sformatf("vec%0d_out_valid", i), {63'd0, b64.out_valid}, 64'd1);
        chk($sformatf("vec%0d_out_data", i), b64.out_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_out_misalign", i), {63'd0, b64.out_misalign}, {63'd0, vecs[i].exp_mis});
      end
    end
    b64.in_valid = 1'b0;
    step();
    chk("idle_out_valid32", {63'd0, b32.out_valid}, 64'd0);
    chk("idle_out_valid64", {63'd0, b64.out_valid}, 64'd0);

    // Backpressure: A,B,C,D with out_ready low for three cycles from A's output cycle
    drive32(1'b1, PASS, 32'hAAAA0001, 2'd0);
    step();
    chk("bp_A_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("bp_A_data", {32'd0, b32.out_data}, 64'hAAAA0001);
    b32.out_ready = 1'b0;
    drive32(1'b1, PASS, 32'hBBBB0002, 2'd0);
    step();
    chk("bp_in_ready_drop", {63'd0, b32.in_ready}, 64'd0);
    chk("bp_A_hold1", {32'd0, b32.out_data}, 64'hAAAA0001);
    drive32(1'b1, PASS, 32'hCCCC0003, 2'd0);
    step();
    chk("bp_in_ready_low2", {63'd0, b32.in_ready}, 64'd0);
    chk("bp_A_hold2_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("bp_A_hold2", {32'd0, b32.out_data}, 64'hAAAA0001);
    step();
    chk("bp_A_hold3", {32'd0, b32.out_data}, 64'hAAAA0001);
    chk("bp_A_hold3_mis", {63'd0, b32.out_misalign}, 64'd0);
    b32.out_ready = 1'b1;
    step();
    chk("bp_B_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("bp_B_data", {32'd0, b32.out_data}, 64'hBBBB0002);
    chk("bp_in_ready_back", {63'd0, b32.in_ready}, 64'd1);
    step();
    chk("bp_C_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("bp_C_data", {32'd0, b32.out_data}, 64'hCCCC0003);
    drive32(1'b1, PASS, 32'hDDDD0004, 2'd0);
    step();
    chk("bp_D_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("bp_D_data", {32'd0, b32.out_data}, 64'hDDDD0004);
    b32.in_valid = 1'b0;
    step();
    chk("bp_drained", {63'd0, b32.out_valid}, 64'd0);

    // Flush with main and skid full while E is offered (out_ready also high: flush wins)
    b32.out_ready = 1'b0;
    drive32(1'b1, PASS, 32'h11110001, 2'd0);
    step();
    drive32(1'b1, PASS, 32'h22220002, 2'd0);
    step();
    chk("fl_skid_full", {63'd0, b32.in_ready}, 64'd0);
    drive32(1'b1, PASS, 32'hEEEE000E, 2'd0);
    b32.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_out_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("fl_in_ready", {63'd0, b32.in_ready}, 64'd1);
    chk("fl_out_data", {32'd0, b32.out_data}, 64'd0);
    drive32(1'b1, PASS, 32'hFFFF000F, 2'd0);
    step();
    chk("fl_F_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("fl_F_data", {32'd0, b32.out_data}, 64'hFFFF000F);
    b32.in_valid = 1'b0;
    step();
    chk("fl_no_E", {63'd0, b32.out_valid}, 64'd0);
    // Beat accepted in the flush cycle is dropped
    drive32(1'b1, PASS, 32'h99990009, 2'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    chk("fl_drop_valid", {63'd0, b32.out_valid}, 64'd0);
    step();
    chk("fl_drop_gone", {63'd0, b32.out_valid}, 64'd0);

    // Asynchronous reset mid-stream with skid full
    b32.out_ready = 1'b0;
    drive32(1'b1, LH, 32'h12345678, 2'd1);
    step();
    drive32(1'b1, PASS, 32'h55550005, 2'd0);
    step();
    b32.in_valid = 1'b0;
    chk("ar_pre_mis", {63'd0, b32.out_misalign}, 64'd1);
    chk("ar_pre_skid", {63'd0, b32.in_ready}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", {63'd0, b32.out_valid}, 64'd0);
    chk("ar_out_data", {32'd0, b32.out_data}, 64'd0);
    chk("ar_out_misalign", {63'd0, b32.out_misalign}, 64'd0);
    chk("ar_in_ready", {63'd0, b32.in_ready}, 64'd1);
    step();
    chk("ar_hold_valid", {63'd0, b32.out_valid}, 64'd0);
    reset_n = 1'b1;
    b32.out_ready = 1'b1;
    drive32(1'b1, LBU, 32'h00AB0000, 2'd2);
    step();
    chk("ar_first_valid", {63'd0, b32.out_valid}, 64'd1);
    chk("ar_first_data", {32'd0, b32.out_data}, 64'h000000AB);
    b32.in_valid = 1'b0;
    step();
    chk("ar_after_empty", {63'd0, b32.out_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
